sreg_sipo_rx: RTL and testbench

//   Serial-in / parallel-out receiver: deserialises a bit stream (one bit per qualified clock)

---
 rtl/sreg_sipo_rx.sv | 88 ++++++++
 tb/tb_sreg_sipo_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sreg_sipo_rx.sv
// ============================================================================
// sreg_sipo_rx : serial-in / parallel-out receiver with one-word holding
//                register on a valid/ready output port.
// Revision 1.0
// ============================================================================
`default_nettype none

module sreg_sipo_rx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sof,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  sr;
  logic [N-1:0]  shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {sr[N-2:0], sin};
    end else begin : g_lsb_first
      assign shifted = {sin, sr[N-1:1]};
    end
  endgenerate

  assign busy = (state == SHIFT);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      count      <= '0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      // Consume first; a word completing this same edge re-asserts valid below.
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (sin_valid) begin
        sr <= shifted;
        if (sof) begin
          count <= CW'(1);
          state <= SHIFT;
          if (count != '0) begin
            frame_err <= 1'b1;
          end
        end else if (count == LAST) begin
          count <= '0;
          state <= IDLE;
          if (!dout_valid || dout_ready) begin
            dout       <= shifted;
            dout_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          count <= count + CW'(1);
          state <= SHIFT;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sreg_sipo_rx.sv
// ============================================================================
// tb_sreg_sipo_rx : self-checking bench, MSB-first and LSB-first instances
//                   driven in parallel and compared against a bit-queue model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sreg_sipo_rx;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic sof = 1'b0;
  logic dout_ready = 1'b0;

  logic [N-1:0] doa, dob;
  logic dva, dvb, busya, busyb, ova, ovb, fea, feb;

  int checks = 0;
  int failures = 0;

  // Model: bits of the word in progress, in arrival order.
  bit           q[$];
  logic [N-1:0] m_msb, m_lsb;
  logic         m_dv, m_busy, m_ovr, m_ferr;

  always #5 clk = ~clk;

  sreg_sipo_rx #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .sys_clk(clk), .sys_rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(doa), .dout_valid(dva), .dout_ready(dout_ready),
    .busy(busya), .overrun(ova), .frame_err(fea)
  );

  sreg_sipo_rx #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .sys_clk(clk), .sys_rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dob), .dout_valid(dvb), .dout_ready(dout_ready),
    .busy(busyb), .overrun(ovb), .frame_err(feb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_msb = '0; m_lsb = '0;
    m_dv = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic f, input logic r);
    logic old_dv;
    old_dv = m_dv;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    if (m_dv && r) m_dv = 1'b0;
    if (v) begin
      if (f) begin
        if (q.size() != 0) m_ferr = 1'b1;
        q.delete();
      end
      q.push_back(s);
      if (q.size() == N) begin
        if (!old_dv || r) begin
          for (int i = 0; i < N; i++) begin
            m_msb[N-1-i] = q[i];
            m_lsb[i]     = q[i];
          end
          m_dv = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        q.delete();
      end
    end
    m_busy = (q.size() != 0);
  endtask

  task automatic compare();
    chk("dout_msb",  doa,   m_msb);
    chk("dout_lsb",  dob,   m_lsb);
    chk("valid_msb", dva,   m_dv);
    chk("valid_lsb", dvb,   m_dv);
    chk("busy_msb",  busya, m_busy);
    chk("busy_lsb",  busyb, m_busy);
    chk("ovr_msb",   ova,   m_ovr);
    chk("ovr_lsb",   ovb,   m_ovr);
    chk("ferr_msb",  fea,   m_ferr);
    chk("ferr_lsb",  feb,   m_ferr);
  endtask

  task automatic cycle(input logic v, input logic s, input logic f, input logic r);
    sin_valid = v; sin = s; sof = f; dout_ready = r;
    model_step(v, s, f, r);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sin_valid = 1'b0; sin = 1'b0; sof = 1'b0; dout_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare();
    rst = 1'b0;
  endtask

  // Word sent most-significant bit first, sof on the first bit.
  task automatic send_word(input logic [N-1:0] w, input logic r_mid, input logic r_last);
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, w[N-1-i], i == 0, (i == N - 1) ? r_last : r_mid);
    end
  endtask

  initial begin
    logic [N-1:0] w;
    do_reset();
    chk("reset_dout",  doa, 8'h00);
    chk("reset_valid", dva, 1'b0);
    chk("reset_busy",  busya, 1'b0);

    // Back-to-back A5, ready held high.
    w = 8'hA5;
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, w[N-1-i], i == 0, 1'b1);
      if (i < N - 1) begin
        chk("a5_busy_mid", busya, 1'b1);
        chk("a5_valid_early", dva, 1'b0);
      end
    end
    chk("a5_dout", doa, 8'hA5);
    chk("a5_valid", dva, 1'b1);
    chk("a5_busy_end", busya, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_valid_drop", dva, 1'b0);

    // Same stream with random gaps.
    for (int i = 0; i < N; i++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, w[N-1-i], i == 0, 1'b1);
    end
    chk("gap_dout", doa, 8'hA5);
    chk("gap_valid", dva, 1'b1);

    // Ready low: second word overruns.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("ovr_pulse", ova, 1'b1);
    chk("ovr_dout", doa, 8'h3C);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_pulse_end", ova, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_valid_drop", dva, 1'b0);

    // Consume coinciding with completion.
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b1);
    chk("swap_dout", doa, 8'hC3);
    chk("swap_valid", dva, 1'b1);
    chk("swap_no_ovr", ova, 1'b0);

    // Partial word interrupted by sof.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, i == 0, 1'b1);
    w = 8'h81;
    cycle(1'b1, w[7], 1'b1, 1'b1);
    chk("ferr_pulse", fea, 1'b1);
    for (int i = 1; i < N; i++) cycle(1'b1, w[N-1-i], 1'b0, 1'b1);
    chk("ferr_dout", doa, 8'h81);
    chk("ferr_once", fea, 1'b0);

    // LSB-first ordering: 1,1,0,0,0,0,0,0.
    w = 8'hC0;
    send_word(w, 1'b1, 1'b1);
    chk("lsb_dout", dob, 8'h03);
    chk("msb_dout_c0", doa, 8'hC0);

    // Reset mid-word, then a clean word.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, i == 0, 1'b1);
    do_reset();
    chk("midrst_dout", doa, 8'h00);
    chk("midrst_valid", dva, 1'b0);
    chk("midrst_busy", busya, 1'b0);
    send_word(8'h5A, 1'b1, 1'b1);
    chk("post_rst_dout", doa, 8'h5A);
    chk("post_rst_lsb", dob, 8'h5A);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
